norm_frame_sequencer: RTL and testbench
=======================================

# norm_frame_sequencer

Frame-level controller for the crop-filter → normalisation path. It accepts one `ap_start` per frame and latches that frame's normalisation denominator. It launches the crop filter, then enables the normaliser's output stream once the crop filter reports done. It counts the `OUT_ROWS*OUT_COLS` output beats, generating row and frame sideband, and returns a single `ap_done` per completed frame, with a stall watchdog.

## Interface
Parameters:
- `PIXEL_BIT_WIDTH`, 10, width of pixel data and of the denominator.
- `OUT_ROWS`, 10, rows per output frame (≥1).
- `OUT_COLS`, 10, columns per output frame (≥1).
- `TIMEOUT_CYCLES`, 4096, number of no-progress cycles before abort (≥2).

Ports:
- `clk` in 1: single clock for all logic.
- `s_axis_resetn` in 1: reset, asynchronous, active-low.
- `ap_start` in 1: frame request. Sampled only in IDLE.
- `ap_done` out 1: one-cycle pulse when a frame completes.
- `ap_ready` out 1: high in IDLE, i.e. a start will be accepted.
- `ap_idle` out 1: high in IDLE.
- `norm_denominator` in PIXEL_BIT_WIDTH: denominator value, sampled on the accepted start.
- `nr_denominator` out PIXEL_BIT_WIDTH: latched denominator, held stable for the whole frame.
- `cf_ap_start` out 1: one-cycle start pulse to the crop filter.
- `cf_ap_done` in 1: crop-filter completion pulse.
- `norm_en` out 1: enable for the normaliser output stream. High only in NORM.
- `mon_tvalid` in 1: tap of the normaliser's `m_axis_tvalid`.
- `mon_tready` in 1: tap of the downstream `m_axis_tready`.
- `m_axis_tlast` out 1: high during the last beat of each row. Combinational, aligned with the tapped beat.
- `m_axis_tuser` out 1: high during the first beat of the frame. Combinational, aligned with the tapped beat.
- `frame_count` out 16: number of completed frames. Wraps from 0xFFFF to 0.
- `timeout_err` out 1: sticky error flag. Cleared only by reset.

## Operation
- States are IDLE, CROP_ISSUE, CROP_WAIT, NORM, DONE.
- IDLE → CROP_ISSUE on `ap_start`. In the same edge the block latches `norm_denominator` into `nr_denominator` and clears the row/column counters and the watchdog.
- CROP_ISSUE: `cf_ap_start`=1 for exactly this one cycle, then the state moves unconditionally to CROP_WAIT. A `cf_ap_done` seen in CROP_ISSUE is ignored.
- CROP_WAIT → NORM on `cf_ap_done`.
- NORM:
  - `norm_en`=1.
  - A beat is `mon_tvalid & mon_tready & norm_en`.
  - Each beat advances `col`. At `col==OUT_COLS-1`, `col` wraps to 0 and `row` increments.
  - A beat with `row==OUT_ROWS-1` and `col==OUT_COLS-1` moves the state to DONE.
- DONE: `ap_done`=1 for one cycle and `frame_count` increments. Next state is IDLE.
- `m_axis_tlast` = `norm_en & (col==OUT_COLS-1)`.
- `m_axis_tuser` = `norm_en & row==0 & col==0`.
- Beats arriving outside NORM are not counted.
- Watchdog:
  - Counts cycles in CROP_WAIT or NORM.
  - Cleared on any state entry and on every beat.
  - On reaching `TIMEOUT_CYCLES-1`, it sets `timeout_err` and returns the FSM to IDLE. No `ap_done` is issued and `frame_count` is unchanged.
- `ap_start` outside IDLE is ignored; it is not queued.
- Counter widths: `col` is `$clog2(OUT_COLS)` bits, `row` is `$clog2(OUT_ROWS)` bits, each with a minimum of 1 bit. The watchdog is `$clog2(TIMEOUT_CYCLES)` bits.

## Timing
- Reset values (on `s_axis_resetn`=0, asynchronous):
  - State is IDLE, so `ap_ready`=1 and `ap_idle`=1.
  - `ap_done`=0, `cf_ap_start`=0, `norm_en`=0.
  - `nr_denominator`=0, `frame_count`=0, `timeout_err`=0, counters=0.
- Reset deasserted mid-frame: the block restarts in IDLE with no `ap_done`.
- Latency from accepted `ap_start` (edge N):
  - `cf_ap_start` is high in cycle N+1.
  - `cf_ap_done` is honoured from N+2 onward.
  - `norm_en` rises the cycle after `cf_ap_done` is sampled.
- Latency from the final beat (edge M): `ap_done` is high in cycle M+1 and `ap_ready` in cycle M+2.
- With zero stalls, the minimum frame is 3 + (cf latency) + `OUT_ROWS*OUT_COLS` + 1 cycles.
- Simultaneous final beat and watchdog expiry: the beat wins, because the beat clears the watchdog. The frame completes normally.
- The `ap_done` pulse and a new `ap_start` cannot overlap, since `ap_start` is only sampled in IDLE.

## Structure
- Shared package `norm_pkg`:
  - enum `seq_state_t` holding the five states.
  - localparam `FRAME_BEATS`.
  - `FRAME_CNT_W`=16.
- Single sub-module `rowcol_counter` (parameters `OUT_ROWS`/`OUT_COLS`). Inputs: `clr`, `adv`. Outputs: `row`, `col`, `last_col`, `last_beat`, `first_beat`.
- Watchdog and FSM live in the top level.

## Test plan
- Nominal run with OUT_ROWS=OUT_COLS=4: `ap_start`; `cf_ap_done` 5 cycles after `cf_ap_start`; 16 beats with `mon_tready`=1. Required: one `cf_ap_start` pulse, exactly one `ap_done` one cycle after beat 16, `tlast` on beats 4/8/12/16, `tuser` on beat 1 only, `frame_count`=1.
- Backpressure: `mon_tready` toggling with a 50% random pattern. Required: only handshaked beats are counted, `ap_done` appears after beat 16, and no double counting during stalls.
- Denominator latch: `norm_denominator`=37 at start, changed to 200 mid-frame. Required: `nr_denominator` stays 37 until the next accepted start.
- Ignored events: `ap_start` pulsed during NORM, and `cf_ap_done` asserted in the CROP_ISSUE cycle. Required: no second frame is started and the FSM waits for a later `cf_ap_done`.
- Watchdog with TIMEOUT_CYCLES=16: `cf_ap_done` never arrives. Required: `timeout_err`=1 after 16 cycles in CROP_WAIT, FSM in IDLE, no `ap_done`, `frame_count` unchanged. A following normal frame completes with `timeout_err` still 1.
- Async reset mid-NORM after beat 7: all outputs take their reset values immediately. A new `ap_start` then yields a full 16-beat frame with `tuser` on the first beat.

Source files
------------

// File: rtl/norm_pkg.sv
// Shared types and constants for the crop-filter -> normaliser frame sequencer.
package norm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CROP_ISSUE,
    ST_CROP_WAIT,
    ST_NORM,
    ST_DONE
  } seq_state_t;

  localparam int DEF_OUT_ROWS = 10;
  localparam int DEF_OUT_COLS = 10;
  localparam int FRAME_BEATS  = DEF_OUT_ROWS * DEF_OUT_COLS;
  localparam int FRAME_CNT_W  = 16;

  // Debug view of the sequencer; row/col are zero-extended into fixed fields.
  typedef struct packed {
    seq_state_t state;
    logic [7:0] row;
    logic [7:0] col;
  } seq_dbg_t;

  // Counter width for a count of n values, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rowcol_counter.sv
// Row/column position of the current output beat within a frame.
module rowcol_counter
  import norm_pkg::*;
#(
  parameter int OUT_ROWS = DEF_OUT_ROWS,
  parameter int OUT_COLS = DEF_OUT_COLS
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clr,
  input  logic                             adv,
  output logic [cnt_width(OUT_ROWS)-1:0]   row,
  output logic [cnt_width(OUT_COLS)-1:0]   col,
  output logic                             last_col,
  output logic                             last_beat,
  output logic                             first_beat
);

  localparam int RW = cnt_width(OUT_ROWS);
  localparam int CW = cnt_width(OUT_COLS);
  localparam logic [RW-1:0] LAST_ROW = RW'(OUT_ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(OUT_COLS - 1);

  assign last_col   = (col == LAST_COL);
  assign last_beat  = last_col && (row == LAST_ROW);
  assign first_beat = (row == '0) && (col == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (adv) begin
      if (last_col) begin
        col <= '0;
        // Row wraps after the final beat so a non-power-of-two frame stays in range.
        row <= last_beat ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/norm_frame_sequencer.sv
// Frame controller: launches the crop filter, gates the normaliser stream,
// counts output beats for tlast/tuser sideband and guards the frame with a watchdog.
module norm_frame_sequencer
  import norm_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH = 10,
  parameter int OUT_ROWS        = DEF_OUT_ROWS,
  parameter int OUT_COLS        = DEF_OUT_COLS,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                       clk,
  input  logic                       s_axis_resetn,
  input  logic                       ap_start,
  output logic                       ap_done,
  output logic                       ap_ready,
  output logic                       ap_idle,
  input  logic [PIXEL_BIT_WIDTH-1:0] norm_denominator,
  output logic [PIXEL_BIT_WIDTH-1:0] nr_denominator,
  output logic                       cf_ap_start,
  input  logic                       cf_ap_done,
  output logic                       norm_en,
  input  logic                       mon_tvalid,
  input  logic                       mon_tready,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tuser,
  output logic [FRAME_CNT_W-1:0]     frame_count,
  output logic                       timeout_err,
  output seq_dbg_t                   dbg
);

  localparam int RW = cnt_width(OUT_ROWS);
  localparam int CW = cnt_width(OUT_COLS);
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

  seq_state_t    state, state_next;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          last_col, last_beat, first_beat;
  logic [WW-1:0] wd;
  logic          beat, start_accept, watching, progress, wd_expire;

  // A beat is a tapped tvalid&tready handshake; it only counts while norm_en is high.
  assign beat         = mon_tvalid & mon_tready & norm_en;
  assign start_accept = (state == ST_IDLE) & ap_start;
  assign watching     = (state == ST_CROP_WAIT) | (state == ST_NORM);
  assign progress     = beat | ((state == ST_CROP_WAIT) & cf_ap_done);
  assign wd_expire    = watching & ~progress & (wd == WD_LAST);

  assign ap_idle      = (state == ST_IDLE);
  assign ap_ready     = (state == ST_IDLE);
  assign cf_ap_start  = (state == ST_CROP_ISSUE);
  assign norm_en      = (state == ST_NORM);
  assign ap_done      = (state == ST_DONE);
  assign m_axis_tlast = norm_en & last_col;
  assign m_axis_tuser = norm_en & first_beat;

  rowcol_counter #(
    .OUT_ROWS (OUT_ROWS),
    .OUT_COLS (OUT_COLS)
  ) u_rowcol (
    .clk        (clk),
    .rst_n      (s_axis_resetn),
    .clr        (start_accept),
    .adv        (beat),
    .row        (row),
    .col        (col),
    .last_col   (last_col),
    .last_beat  (last_beat),
    .first_beat (first_beat)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:       if (ap_start) state_next = ST_CROP_ISSUE;
      ST_CROP_ISSUE: state_next = ST_CROP_WAIT;
      ST_CROP_WAIT: begin
        if (cf_ap_done)     state_next = ST_NORM;
        else if (wd_expire) state_next = ST_IDLE;
      end
      ST_NORM: begin
        if (beat && last_beat) state_next = ST_DONE;
        else if (wd_expire)    state_next = ST_IDLE;
      end
      ST_DONE:       state_next = ST_IDLE;
      default:       state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge s_axis_resetn) begin
    if (!s_axis_resetn) begin
      state          <= ST_IDLE;
      nr_denominator <= '0;
      frame_count    <= '0;
      timeout_err    <= 1'b0;
      wd             <= '0;
    end else begin
      state <= state_next;
      if (start_accept) nr_denominator <= norm_denominator;
      if (state == ST_DONE) frame_count <= frame_count + 1'b1;
      if (wd_expire) timeout_err <= 1'b1;
      if ((state_next != state) || beat) wd <= '0;
      else if (watching)                 wd <= wd + 1'b1;
    end
  end

  always_comb begin
    dbg       = '0;
    dbg.state = state;
    dbg.row   = 8'(row);
    dbg.col   = 8'(col);
  end

endmodule

// File: tb/tb_norm_frame_sequencer.sv
// Directed bench for norm_frame_sequencer: frame-level reference model, per-cycle
// compare, and literal checks on pulse counts, sideband masks and latencies.
module tb_norm_frame_sequencer;
  import norm_pkg::*;

  localparam int PW = 10;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ap_start = 1'b0;
  logic          cf_ap_done = 1'b0;
  logic          mon_tvalid = 1'b0;
  logic          mon_tready = 1'b0;
  logic [PW-1:0] norm_denominator = '0;
  logic          ap_done, ap_ready, ap_idle, cf_ap_start, norm_en;
  logic          m_axis_tlast, m_axis_tuser, timeout_err;
  logic [PW-1:0] nr_denominator;
  logic [15:0]   frame_count;
  seq_dbg_t      dbg;

  norm_frame_sequencer #(
    .PIXEL_BIT_WIDTH (PW),
    .OUT_ROWS        (R),
    .OUT_COLS        (C),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk              (clk),
    .s_axis_resetn    (rst_n),
    .ap_start         (ap_start),
    .ap_done          (ap_done),
    .ap_ready         (ap_ready),
    .ap_idle          (ap_idle),
    .norm_denominator (norm_denominator),
    .nr_denominator   (nr_denominator),
    .cf_ap_start      (cf_ap_start),
    .cf_ap_done       (cf_ap_done),
    .norm_en          (norm_en),
    .mon_tvalid       (mon_tvalid),
    .mon_tready       (mon_tready),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tuser     (m_axis_tuser),
    .frame_count      (frame_count),
    .timeout_err      (timeout_err),
    .dbg              (dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: phase of the frame, beats delivered so far,
  // consecutive cycles without progress, frames completed.
  int          m_phase = 0;   // 0 idle, 1 crop launch, 2 crop wait, 3 streaming, 4 done
  int          m_beats = 0;
  int          m_stall = 0;
  logic [15:0] m_frames = '0;
  logic [PW-1:0] m_den = '0;
  bit          m_terr = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_beats = 0; m_stall = 0;
      m_frames = '0; m_den = '0; m_terr = 1'b0;
    end else begin
      case (m_phase)
        0: if (ap_start) begin
          m_phase = 1; m_den = norm_denominator; m_beats = 0; m_stall = 0;
        end
        1: begin m_phase = 2; m_stall = 0; end
        2: if (cf_ap_done) begin
          m_phase = 3; m_stall = 0;
        end else begin
          m_stall++;
          if (m_stall == TO) begin m_terr = 1'b1; m_phase = 0; end
        end
        3: if (mon_tvalid && mon_tready) begin
          m_beats++; m_stall = 0;
          if (m_beats == R * C) m_phase = 4;
        end else begin
          m_stall++;
          if (m_stall == TO) begin m_terr = 1'b1; m_phase = 0; end
        end
        default: begin m_frames = m_frames + 16'd1; m_phase = 0; end
      endcase
    end
  end

  // Scoreboard compare on every falling edge
  always @(negedge clk) begin
    chk("ap_idle",      {31'd0, ap_idle},      {31'd0, m_phase == 0});
    chk("ap_ready",     {31'd0, ap_ready},     {31'd0, m_phase == 0});
    chk("cf_ap_start",  {31'd0, cf_ap_start},  {31'd0, m_phase == 1});
    chk("norm_en",      {31'd0, norm_en},      {31'd0, m_phase == 3});
    chk("ap_done",      {31'd0, ap_done},      {31'd0, m_phase == 4});
    chk("tlast",        {31'd0, m_axis_tlast}, {31'd0, (m_phase == 3) && ((m_beats % C) == C - 1)});
    chk("tuser",        {31'd0, m_axis_tuser}, {31'd0, (m_phase == 3) && (m_beats == 0)});
    chk("nr_denom",     32'(nr_denominator),   32'(m_den));
    chk("frame_count",  32'(frame_count),      32'(m_frames));
    chk("timeout_err",  {31'd0, timeout_err},  {31'd0, m_terr});
  end

  // Event monitor feeding the literal checks
  int cyc = 0;
  int n_cf, n_done, beat_idx, last_beat_cyc, done_cyc, issue_cyc, terr_cyc;
  logic [31:0] tlast_mask, tuser_mask;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (cf_ap_start) begin n_cf++; issue_cyc = cyc; end
    if (ap_done) begin n_done++; done_cyc = cyc; end
    if (norm_en && mon_tvalid && mon_tready) begin
      beat_idx++;
      if (beat_idx <= 32) begin
        if (m_axis_tlast) tlast_mask[beat_idx-1] = 1'b1;
        if (m_axis_tuser) tuser_mask[beat_idx-1] = 1'b1;
      end
      last_beat_cyc = cyc;
    end
    if (timeout_err && terr_cyc < 0) terr_cyc = cyc;
  end

  // Driver tasks: inputs change 1 time unit after the rising edge
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_mon();
    n_cf = 0; n_done = 0; beat_idx = 0; last_beat_cyc = 0; done_cyc = 0;
    issue_cyc = 0; terr_cyc = -1; tlast_mask = '0; tuser_mask = '0;
  endtask

  task automatic start_frame(input logic [PW-1:0] den, input bit cf_in_issue);
    ap_start = 1'b1; norm_denominator = den;
    step(1);
    ap_start = 1'b0;
    if (cf_in_issue) cf_ap_done = 1'b1;
    step(1);
    cf_ap_done = 1'b0;
  endtask

  task automatic crop_done(input int lat);
    step(lat);
    cf_ap_done = 1'b1;
    step(1);
    cf_ap_done = 1'b0;
  endtask

  task automatic stream(input int nbeats, input bit rnd_ready, input int den_change_at,
                        input int start_at);
    int  stall = 0;
    int  guard = 0;
    bit  pulsed = 1'b0;
    mon_tvalid = 1'b1;
    while (beat_idx < nbeats && guard < 200) begin
      if (rnd_ready) mon_tready = (stall >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
      else           mon_tready = 1'b1;
      stall = mon_tready ? 0 : stall + 1;
      if (!pulsed && start_at > 0 && beat_idx >= start_at) begin
        ap_start = 1'b1; pulsed = 1'b1;
      end else begin
        ap_start = 1'b0;
      end
      if (den_change_at > 0 && beat_idx >= den_change_at) norm_denominator = 10'd200;
      step(1);
      guard++;
    end
    mon_tvalid = 1'b0; mon_tready = 1'b0; ap_start = 1'b0;
    chk("beats_delivered", 32'(beat_idx), 32'(nbeats));
  endtask

  task automatic wait_done();
    int g = 0;
    while (n_done == 0 && g < 20) begin step(1); g++; end
    step(2);
  endtask

  initial begin
    clear_mon();
    // Reset state
    step(2);
    chk("rst_ap_idle", {31'd0, ap_idle}, 32'd1);
    chk("rst_ap_ready", {31'd0, ap_ready}, 32'd1);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_nr_denom", 32'(nr_denominator), 32'd0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    rst_n = 1'b1;
    step(1);

    // Nominal frame
    clear_mon();
    start_frame(10'd5, 1'b0);
    crop_done(4);
    stream(16, 1'b0, 0, 0);
    wait_done();
    chk("nom_cf_pulses", 32'(n_cf), 32'd1);
    chk("nom_done_pulses", 32'(n_done), 32'd1);
    chk("nom_done_latency", 32'(done_cyc - last_beat_cyc), 32'd1);
    chk("nom_tlast_mask", tlast_mask, 32'h0000_8888);
    chk("nom_tuser_mask", tuser_mask, 32'h0000_0001);
    chk("nom_frame_count", 32'(frame_count), 32'd1);

    // Backpressure with a denominator change mid-frame
    clear_mon();
    start_frame(10'd37, 1'b0);
    crop_done(2);
    stream(16, 1'b1, 5, 0);
    wait_done();
    chk("bp_done_pulses", 32'(n_done), 32'd1);
    chk("bp_done_latency", 32'(done_cyc - last_beat_cyc), 32'd1);
    chk("bp_tlast_mask", tlast_mask, 32'h0000_8888);
    chk("bp_nr_denom", 32'(nr_denominator), 32'd37);
    chk("bp_frame_count", 32'(frame_count), 32'd2);

    // Ignored cf_ap_done in the launch cycle and ap_start during streaming
    clear_mon();
    start_frame(10'd200, 1'b1);
    step(3);
    chk("ign_state_wait", 32'(dbg.state), 32'(ST_CROP_WAIT));
    chk("ign_norm_en", {31'd0, norm_en}, 32'd0);
    crop_done(1);
    stream(16, 1'b0, 0, 3);
    wait_done();
    step(3);
    chk("ign_cf_pulses", 32'(n_cf), 32'd1);
    chk("ign_done_pulses", 32'(n_done), 32'd1);
    chk("ign_idle", {31'd0, ap_idle}, 32'd1);
    chk("ign_nr_denom", 32'(nr_denominator), 32'd200);
    chk("ign_frame_count", 32'(frame_count), 32'd3);

    // Watchdog: crop filter never finishes
    clear_mon();
    start_frame(10'd9, 1'b0);
    step(25);
    chk("wd_expiry_cycle", 32'(terr_cyc - issue_cyc), 32'd17);
    chk("wd_timeout_err", {31'd0, timeout_err}, 32'd1);
    chk("wd_idle", {31'd0, ap_idle}, 32'd1);
    chk("wd_no_done", 32'(n_done), 32'd0);
    chk("wd_frame_count", 32'(frame_count), 32'd3);
    clear_mon();
    start_frame(10'd11, 1'b0);
    crop_done(3);
    stream(16, 1'b0, 0, 0);
    wait_done();
    chk("wd_next_done", 32'(n_done), 32'd1);
    chk("wd_next_frame_count", 32'(frame_count), 32'd4);
    chk("wd_err_sticky", {31'd0, timeout_err}, 32'd1);

    // Asynchronous reset after beat 7
    clear_mon();
    start_frame(10'd21, 1'b0);
    crop_done(2);
    stream(7, 1'b0, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_ap_idle", {31'd0, ap_idle}, 32'd1);
    chk("ar_norm_en", {31'd0, norm_en}, 32'd0);
    chk("ar_ap_done", {31'd0, ap_done}, 32'd0);
    chk("ar_cf_start", {31'd0, cf_ap_start}, 32'd0);
    chk("ar_tuser", {31'd0, m_axis_tuser}, 32'd0);
    chk("ar_nr_denom", 32'(nr_denominator), 32'd0);
    chk("ar_frame_count", 32'(frame_count), 32'd0);
    chk("ar_timeout_err", {31'd0, timeout_err}, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(1);
    clear_mon();
    start_frame(10'd3, 1'b0);
    crop_done(2);
    stream(16, 1'b0, 0, 0);
    wait_done();
    chk("ar_next_done", 32'(n_done), 32'd1);
    chk("ar_next_tuser_mask", tuser_mask, 32'h0000_0001);
    chk("ar_next_tlast_mask", tlast_mask, 32'h0000_8888);
    chk("ar_next_frame_count", 32'(frame_count), 32'd1);

    // Final report
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
